// File: rtl/fecha_pkg.sv
// Shared definitions for the date-field sequencer: field select codes,
// button bit positions, state encoding and small decode helpers.
package fecha_pkg;

    localparam logic [3:0] SEL_DIA    = 4'd0;
    localparam logic [3:0] SEL_MES    = 4'd1;
    localparam logic [3:0] SEL_ANO    = 4'd2;
    localparam logic [3:0] SEL_EDIT   = 4'd4;
    localparam logic [3:0] SEL_REPOSO = 4'd6;

    localparam int BOT_IZQ = 0;
    localparam int BOT_ABA = 1;
    localparam int BOT_DER = 2;
    localparam int BOT_ARR = 3;

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        L_DIA  = 3'd1,
        L_MES  = 3'd2,
        L_ANO  = 3'd3,
        EDITAR = 3'd4,
        E_DIA  = 3'd5,
        E_MES  = 3'd6,
        E_ANO  = 3'd7
    } estado_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic es_lectura(input estado_t s);
        return (s == L_DIA) || (s == L_MES) || (s == L_ANO);
    endfunction

    function automatic logic es_escritura(input estado_t s);
        return (s == E_DIA) || (s == E_MES) || (s == E_ANO);
    endfunction

    function automatic logic es_campo(input estado_t s);
        return es_lectura(s) || es_escritura(s);
    endfunction

    function automatic logic [3:0] sel_de_estado(input estado_t s);
        case (s)
            L_DIA, E_DIA: return SEL_DIA;
            L_MES, E_MES: return SEL_MES;
            L_ANO, E_ANO: return SEL_ANO;
            EDITAR:       return SEL_EDIT;
            default:      return SEL_REPOSO;
        endcase
    endfunction

    // Field that follows s in a read or write sweep; the last field returns to idle.
    function automatic estado_t sig_campo(input estado_t s);
        case (s)
            L_DIA:   return L_MES;
            L_MES:   return L_ANO;
            E_DIA:   return E_MES;
            E_MES:   return E_ANO;
            default: return REPOSO;
        endcase
    endfunction

endpackage

// File: rtl/control_fecha_if.sv
// Button, RTC handshake and bloque_fecha control signals of the date sequencer.
interface control_fecha_if;
    logic       btn_modo;
    logic       btn_arr;
    logic       btn_aba;
    logic       btn_izq;
    logic       btn_der;
    logic       tick_lectura;
    logic       rtc_ocupado;
    logic       rtc_listo;
    logic [3:0] Selec_Demux_DD;
    logic       READ;
    logic       enable_cont_16;
    logic       enable_cont_fecha;
    logic [3:0] IN_bot_fecha;
    logic       rtc_req;
    logic       rtc_wr;
    logic       modo_edicion;
    logic       error_rtc;

    modport master (
        output btn_modo, btn_arr, btn_aba, btn_izq, btn_der,
        output tick_lectura, rtc_ocupado, rtc_listo,
        input  Selec_Demux_DD, READ, enable_cont_16, enable_cont_fecha,
        input  IN_bot_fecha, rtc_req, rtc_wr, modo_edicion, error_rtc
    );

    modport slave (
        input  btn_modo, btn_arr, btn_aba, btn_izq, btn_der,
        input  tick_lectura, rtc_ocupado, rtc_listo,
        output Selec_Demux_DD, READ, enable_cont_16, enable_cont_fecha,
        output IN_bot_fecha, rtc_req, rtc_wr, modo_edicion, error_rtc
    );
endinterface

// File: rtl/control_fecha_gen_pulso_boton.sv
// Turns a debounced button level into single-cycle requests: one on the
// press, then (optionally) repeats while held. A button already held when
// the block becomes enabled stays silent until released and pressed again.
module gen_pulso_boton #(
    parameter bit          REPEAT_EN    = 1'b1,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic reloj,
    input  logic resetM,
    input  logic en,
    input  logic btn,
    output logic pulso
);

    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(REPEAT_RATE - 1);

    logic             btn_prev_r;
    logic             armado_r;
    logic             rep_first_r;
    logic [CNT_W-1:0] rep_cnt_r;
    logic             edge_s;
    logic             rep_s;
    logic [CNT_W-1:0] lim_s;

    assign edge_s = btn & ~btn_prev_r;
    assign lim_s  = rep_first_r ? RATE_LIM : DELAY_LIM;
    assign rep_s  = REPEAT_EN & en & btn & armado_r & ~edge_s & (rep_cnt_r == lim_s);

    // Request goes out only while enabled.
    always_comb begin
        pulso = 1'b0;
        if (en) begin
            pulso = edge_s | rep_s;
        end else begin
            pulso = 1'b0;
        end
    end

    // Edge history, arm flag and auto-repeat interval counter.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            btn_prev_r  <= 1'b0;
            armado_r    <= 1'b0;
            rep_first_r <= 1'b0;
            rep_cnt_r   <= '0;
        end else begin
            btn_prev_r <= btn;
            armado_r   <= en & btn & (edge_s | armado_r);
            if (!en || !btn || edge_s || rep_s) begin
                rep_cnt_r <= '0;
            end else begin
                rep_cnt_r <= rep_cnt_r + CNT_W'(1);
            end
            if (!en || !btn || edge_s) begin
                rep_first_r <= 1'b0;
            end else if (rep_s) begin
                rep_first_r <= 1'b1;
            end else begin
                rep_first_r <= rep_first_r;
            end
        end
    end

endmodule

// File: rtl/control_fecha.sv
// Date sequencer in front of bloque_fecha: periodic RTC reads of day/month/
// year, interactive edit mode with button pulses, and RTC write-back on exit.
module control_fecha
    import fecha_pkg::*;
#(
    parameter int unsigned TIMEOUT_RTC  = 1000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned EDIT_TIMEOUT = 500_000_000
) (
    input  logic            reloj,
    input  logic            resetM,
    control_fecha_if.slave  bus
);

    localparam int unsigned MAX_P = max_u(max_u(TIMEOUT_RTC, EDIT_TIMEOUT),
                                          max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam int unsigned CNT_W = $clog2(MAX_P + 1);
    localparam logic [CNT_W-1:0] RTC_LIM  = CNT_W'(TIMEOUT_RTC - 1);
    localparam logic [CNT_W-1:0] EDIT_LIM = CNT_W'(EDIT_TIMEOUT - 1);

    estado_t          state_r;
    estado_t          state_next_s;
    logic             modo_prev_r;
    logic             pending_modo_r;
    logic [CNT_W-1:0] field_cnt_r;
    logic [CNT_W-1:0] edit_cnt_r;
    logic             modo_edge_s;
    logic             en_edit_s;
    logic             timeout_s;
    logic             act_s;
    logic             req_arr_s, req_aba_s, req_izq_s, req_der_s;
    logic [3:0]       bot_next_s;

    logic [3:0]       sel_r;
    logic             read_r, en16_r, enf_r, req_r, wr_r, modo_r, err_r;
    logic [3:0]       bot_r;

    assign modo_edge_s = bus.btn_modo & ~modo_prev_r;
    assign en_edit_s   = (state_r == EDITAR);
    assign act_s       = req_arr_s | req_aba_s | req_izq_s | req_der_s;

    gen_pulso_boton #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_arr (.reloj(reloj), .resetM(resetM), .en(en_edit_s), .btn(bus.btn_arr), .pulso(req_arr_s));
    gen_pulso_boton #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_aba (.reloj(reloj), .resetM(resetM), .en(en_edit_s), .btn(bus.btn_aba), .pulso(req_aba_s));
    gen_pulso_boton #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_izq (.reloj(reloj), .resetM(resetM), .en(en_edit_s), .btn(bus.btn_izq), .pulso(req_izq_s));
    gen_pulso_boton #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_der (.reloj(reloj), .resetM(resetM), .en(en_edit_s), .btn(bus.btn_der), .pulso(req_der_s));

    // Next-state selection; also flags an RTC field that ran out of time.
    always_comb begin
        state_next_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            REPOSO: begin
                if (modo_edge_s || pending_modo_r) begin
                    state_next_s = EDITAR;
                end else if (bus.tick_lectura && !bus.rtc_ocupado) begin
                    state_next_s = L_DIA;
                end else begin
                    state_next_s = REPOSO;
                end
            end
            L_DIA, L_MES, L_ANO, E_DIA, E_MES, E_ANO: begin
                if (bus.rtc_listo) begin
                    state_next_s = sig_campo(state_r);
                end else if (field_cnt_r == RTC_LIM) begin
                    state_next_s = REPOSO;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            EDITAR: begin
                if (modo_edge_s) begin
                    state_next_s = E_DIA;
                end else if (!act_s && (edit_cnt_r == EDIT_LIM)) begin
                    state_next_s = REPOSO;
                end else begin
                    state_next_s = EDITAR;
                end
            end
            default: begin
                state_next_s = REPOSO;
            end
        endcase
    end

    // Same-cycle button requests collapse to one pulse: arr > aba > izq > der.
    always_comb begin
        bot_next_s = 4'b0000;
        if (!en_edit_s) begin
            bot_next_s = 4'b0000;
        end else if (req_arr_s) begin
            bot_next_s[BOT_ARR] = 1'b1;
        end else if (req_aba_s) begin
            bot_next_s[BOT_ABA] = 1'b1;
        end else if (req_izq_s) begin
            bot_next_s[BOT_IZQ] = 1'b1;
        end else if (req_der_s) begin
            bot_next_s[BOT_DER] = 1'b1;
        end else begin
            bot_next_s = 4'b0000;
        end
    end

    // State register, edit-entry bookkeeping and the two watchdog counters.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_r        <= REPOSO;
            modo_prev_r    <= 1'b0;
            pending_modo_r <= 1'b0;
            field_cnt_r    <= '0;
            edit_cnt_r     <= '0;
        end else begin
            state_r     <= state_next_s;
            modo_prev_r <= bus.btn_modo;
            if (state_next_s == EDITAR) begin
                pending_modo_r <= 1'b0;
            end else if (modo_edge_s && es_lectura(state_r)) begin
                pending_modo_r <= 1'b1;
            end else begin
                pending_modo_r <= pending_modo_r;
            end
            if ((state_next_s != state_r) || !es_campo(state_r)) begin
                field_cnt_r <= '0;
            end else begin
                field_cnt_r <= field_cnt_r + CNT_W'(1);
            end
            if ((state_r != EDITAR) || act_s) begin
                edit_cnt_r <= '0;
            end else begin
                edit_cnt_r <= edit_cnt_r + CNT_W'(1);
            end
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            sel_r  <= SEL_REPOSO;
            read_r <= 1'b0;
            en16_r <= 1'b0;
            enf_r  <= 1'b0;
            bot_r  <= 4'b0000;
            req_r  <= 1'b0;
            wr_r   <= 1'b0;
            modo_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            sel_r  <= sel_de_estado(state_next_s);
            read_r <= es_lectura(state_next_s);
            en16_r <= (state_next_s == EDITAR);
            enf_r  <= (state_next_s == EDITAR);
            bot_r  <= bot_next_s;
            req_r  <= es_campo(state_next_s);
            wr_r   <= es_escritura(state_next_s);
            modo_r <= (state_next_s == EDITAR);
            err_r  <= timeout_s;
        end
    end

    assign bus.Selec_Demux_DD    = sel_r;
    assign bus.READ              = read_r;
    assign bus.enable_cont_16    = en16_r;
    assign bus.enable_cont_fecha = enf_r;
    assign bus.IN_bot_fecha      = bot_r;
    assign bus.rtc_req           = req_r;
    assign bus.rtc_wr            = wr_r;
    assign bus.modo_edicion      = modo_r;
    assign bus.error_rtc         = err_r;

endmodule

// File: tb/tb_control_fecha.sv
// Directed bench for control_fecha with shortened timing parameters.
module tb_control_fecha;

    logic reloj = 1'b0;
    logic resetM;
    int   n_tests = 0;
    int   n_fail  = 0;

    control_fecha_if bus();

    control_fecha #(
        .TIMEOUT_RTC(8), .REPEAT_DELAY(20), .REPEAT_RATE(5), .EDIT_TIMEOUT(200)
    ) dut (
        .reloj(reloj), .resetM(resetM), .bus(bus)
    );

    always #5 reloj = ~reloj;

    // Waits for an RTC request, records what it shows, acknowledges 3 cycles in.
    task automatic rtc_ack(output logic [3:0] sel_o, output logic rd_o,
                           output logic wr_o, output logic ok_o);
        ok_o = 1'b0; sel_o = 4'hF; rd_o = 1'b0; wr_o = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rtc_req === 1'b1) begin
                ok_o = 1'b1;
                break;
            end
            @(negedge reloj);
        end
        if (ok_o) begin
            sel_o = bus.Selec_Demux_DD; rd_o = bus.READ; wr_o = bus.rtc_wr;
            repeat (2) @(negedge reloj);
            bus.rtc_listo = 1'b1;
            @(negedge reloj);
            bus.rtc_listo = 1'b0;
        end
    endtask

    task automatic test_reset_and_read();
        logic [3:0] sel; logic rd, wr, ok;
        resetM = 1'b1;
        repeat (2) @(negedge reloj);
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd6 || bus.READ !== 1'b0 || bus.enable_cont_16 !== 1'b0 ||
            bus.enable_cont_fecha !== 1'b0 || bus.IN_bot_fecha !== 4'd0 || bus.rtc_req !== 1'b0 ||
            bus.rtc_wr !== 1'b0 || bus.modo_edicion !== 1'b0 || bus.error_rtc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sel=%0d read=%b e16=%b ef=%b bot=%0d req=%b wr=%b modo=%b err=%b, expected sel=6 rest 0",
                     bus.Selec_Demux_DD, bus.READ, bus.enable_cont_16, bus.enable_cont_fecha,
                     bus.IN_bot_fecha, bus.rtc_req, bus.rtc_wr, bus.modo_edicion, bus.error_rtc);
        end
        resetM = 1'b0;
        @(negedge reloj);
        bus.tick_lectura = 1'b1;
        @(negedge reloj);
        bus.tick_lectura = 1'b0;
        for (int f = 0; f < 3; f++) begin
            rtc_ack(sel, rd, wr, ok);
            n_tests++;
            if (ok !== 1'b1 || sel !== 4'(f) || rd !== 1'b1 || wr !== 1'b0) begin
                n_fail++;
                $display("FAIL read_field%0d: req_seen=%b sel=%0d read=%b wr=%b, expected req_seen=1 sel=%0d read=1 wr=0",
                         f, ok, sel, rd, wr, f);
            end
        end
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd6 || bus.rtc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: sel=%0d req=%b, expected sel=6 req=0", bus.Selec_Demux_DD, bus.rtc_req);
        end
    endtask

    task automatic test_edit_repeat();
        logic [3:0] exp;
        bus.btn_modo = 1'b1;
        @(negedge reloj);
        bus.btn_modo = 1'b0;
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd4 || bus.modo_edicion !== 1'b1 || bus.enable_cont_16 !== 1'b1 ||
            bus.enable_cont_fecha !== 1'b1 || bus.READ !== 1'b0 || bus.rtc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_enter: sel=%0d modo=%b e16=%b ef=%b read=%b req=%b, expected sel=4 modo=1 e16=1 ef=1 read=0 req=0",
                     bus.Selec_Demux_DD, bus.modo_edicion, bus.enable_cont_16, bus.enable_cont_fecha,
                     bus.READ, bus.rtc_req);
        end
        @(negedge reloj);
        bus.btn_arr = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge reloj);
            exp = (k == 1 || k == 21 || k == 26 || k == 31) ? 4'd8 : 4'd0;
            n_tests++;
            if (bus.IN_bot_fecha !== exp) begin
                n_fail++;
                $display("FAIL arr_repeat k=%0d: bot=%0d, expected %0d", k, bus.IN_bot_fecha, exp);
            end
            if (k == 31) bus.btn_arr = 1'b0;
        end
    endtask

    task automatic test_priority_and_no_repeat();
        logic [3:0] exp;
        bus.btn_izq = 1'b1;
        bus.btn_arr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge reloj);
            exp = (k == 1) ? 4'd8 : 4'd0;
            n_tests++;
            if (bus.IN_bot_fecha !== exp) begin
                n_fail++;
                $display("FAIL arr_izq_same k=%0d: bot=%0d, expected %0d", k, bus.IN_bot_fecha, exp);
            end
        end
        bus.btn_izq = 1'b0;
        bus.btn_arr = 1'b0;
        repeat (2) @(negedge reloj);
        bus.btn_izq = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge reloj);
            exp = (k == 1) ? 4'd1 : 4'd0;
            n_tests++;
            if (bus.IN_bot_fecha !== exp) begin
                n_fail++;
                $display("FAIL izq_held k=%0d: bot=%0d, expected %0d", k, bus.IN_bot_fecha, exp);
            end
        end
        bus.btn_izq = 1'b0;
        @(negedge reloj);
    endtask

    task automatic test_write_back();
        logic [3:0] sel; logic rd, wr, ok;
        bus.btn_modo = 1'b1;
        @(negedge reloj);
        bus.btn_modo = 1'b0;
        for (int f = 0; f < 3; f++) begin
            rtc_ack(sel, rd, wr, ok);
            n_tests++;
            if (ok !== 1'b1 || sel !== 4'(f) || rd !== 1'b0 || wr !== 1'b1) begin
                n_fail++;
                $display("FAIL write_field%0d: req_seen=%b sel=%0d read=%b wr=%b, expected req_seen=1 sel=%0d read=0 wr=1",
                         f, ok, sel, rd, wr, f);
            end
        end
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd6 || bus.modo_edicion !== 1'b0 || bus.rtc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: sel=%0d modo=%b req=%b, expected sel=6 modo=0 req=0",
                     bus.Selec_Demux_DD, bus.modo_edicion, bus.rtc_req);
        end
    endtask

    task automatic test_timeout_and_reset();
        logic [3:0] sel; logic rd, wr, ok;
        int cyc;
        bus.tick_lectura = 1'b1;
        @(negedge reloj);
        bus.tick_lectura = 1'b0;
        rtc_ack(sel, rd, wr, ok);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge reloj);
            if (bus.error_rtc === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_tests++;
        if (cyc != 8 || bus.Selec_Demux_DD !== 4'd6 || bus.rtc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rtc_timeout: cycles=%0d sel=%0d req=%b, expected cycles=8 sel=6 req=0",
                     cyc, bus.Selec_Demux_DD, bus.rtc_req);
        end
        @(negedge reloj);
        n_tests++;
        if (bus.error_rtc !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_width: error_rtc=%b, expected 0", bus.error_rtc);
        end
        bus.btn_modo = 1'b1;
        @(negedge reloj);
        bus.btn_modo = 1'b0;
        @(negedge reloj);
        bus.btn_modo = 1'b1;
        @(negedge reloj);
        bus.btn_modo = 1'b0;
        rtc_ack(sel, rd, wr, ok);
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd1 || bus.rtc_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL in_e_mes: sel=%0d wr=%b, expected sel=1 wr=1", bus.Selec_Demux_DD, bus.rtc_wr);
        end
        resetM = 1'b1;
        @(negedge reloj);
        resetM = 1'b0;
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd6 || bus.rtc_req !== 1'b0 || bus.rtc_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_write: sel=%0d req=%b wr=%b, expected sel=6 req=0 wr=0",
                     bus.Selec_Demux_DD, bus.rtc_req, bus.rtc_wr);
        end
    endtask

    task automatic test_pending_and_idle();
        logic [3:0] sel; logic rd, wr, ok, seen_req;
        int cyc;
        @(negedge reloj);
        bus.tick_lectura = 1'b1;
        @(negedge reloj);
        bus.tick_lectura = 1'b0;
        bus.btn_modo = 1'b1;
        @(negedge reloj);
        bus.btn_modo = 1'b0;
        for (int f = 0; f < 3; f++) begin
            rtc_ack(sel, rd, wr, ok);
            n_tests++;
            if (ok !== 1'b1 || sel !== 4'(f) || rd !== 1'b1) begin
                n_fail++;
                $display("FAIL pend_read%0d: req_seen=%b sel=%0d read=%b, expected req_seen=1 sel=%0d read=1",
                         f, ok, sel, rd, f);
            end
        end
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd6) begin
            n_fail++;
            $display("FAIL pend_idle: sel=%0d, expected 6", bus.Selec_Demux_DD);
        end
        @(negedge reloj);
        n_tests++;
        if (bus.Selec_Demux_DD !== 4'd4 || bus.modo_edicion !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_edit: sel=%0d modo=%b, expected sel=4 modo=1", bus.Selec_Demux_DD, bus.modo_edicion);
        end
        cyc = 0;
        seen_req = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge reloj);
            if (bus.rtc_req !== 1'b0) seen_req = 1'b1;
            if (bus.Selec_Demux_DD !== 4'd4) begin
                cyc = i;
                break;
            end
        end
        repeat (3) begin
            @(negedge reloj);
            if (bus.rtc_req !== 1'b0) seen_req = 1'b1;
        end
        n_tests++;
        if (cyc != 200 || bus.Selec_Demux_DD !== 4'd6 || seen_req !== 1'b0) begin
            n_fail++;
            $display("FAIL edit_idle: cycles=%0d sel=%0d req_seen=%b, expected cycles=200 sel=6 req_seen=0",
                     cyc, bus.Selec_Demux_DD, seen_req);
        end
    endtask

    initial begin
        resetM           = 1'b1;
        bus.btn_modo     = 1'b0;
        bus.btn_arr      = 1'b0;
        bus.btn_aba      = 1'b0;
        bus.btn_izq      = 1'b0;
        bus.btn_der      = 1'b0;
        bus.tick_lectura = 1'b0;
        bus.rtc_ocupado  = 1'b0;
        bus.rtc_listo    = 1'b0;
        test_reset_and_read();
        test_edit_repeat();
        test_priority_and_no_repeat();
        test_write_back();
        test_timeout_and_reset();
        test_pending_and_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
        $fatal(1);
    end

endmodule
